ps2_scan_sequencer: RTL and testbench
=====================================

PS2_SCAN_SEQUENCER -- requirements
Module: ps2_scan_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20000, is the idle-cycle count after which a partial prefix sequence is abandoned.
REQ-002 Parameter FILTER_REPEAT, default 1, where 1 suppresses typematic repeat makes.
REQ-003 clock  in  1  single system clock; all logic on posedge.
REQ-004 resetn  in  1  reset, asynchronous and active-low.
REQ-005 rx_strb  in  1  one-cycle pulse indicating a received PS/2 byte.
REQ-006 rx_data  in  8  received byte, valid only with rx_strb.
REQ-007 rx_error  in  1  one-cycle pulse flagging a parity or framing error on the current frame.
REQ-008 strb  out  1  one-cycle pulse indicating a key event for the keyboard matrix.
REQ-009 make  out  1  key state for the matrix: 0 = pressed, 1 = released (matrix polarity).
REQ-010 code  out  8  scancode low byte with prefixes stripped.
REQ-011 ext  out  1  1 when the event carried an E0 prefix.
REQ-012 pause  out  1  one-cycle pulse on completion of the 8-byte E1 Pause sequence.
REQ-013 bat  out  1  one-cycle pulse when the keyboard self-test byte AA arrives in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, E0, F0, E0F0, E1SKIP.
REQ-015 IDLE transitions:
  - E0 -> E0; F0 -> F0; E1 -> E1SKIP with skip count 7.
  - AA -> bat pulse, stay IDLE.
  - FA, EE, FE, 00, FF SHALL be discarded.
  - Any other byte -> make event (make=0), stay IDLE.
REQ-016 E0: F0 -> E0F0; 12 or 59 (fake shift) -> discard and go IDLE; other byte -> ext make event and go IDLE.
REQ-017 F0: any byte -> break event (make=1, ext=0) and go IDLE.
REQ-018 E0F0: 12 or 59 -> discard and go IDLE; other byte -> ext break event and go IDLE.
REQ-019 E1SKIP: each byte decrements the skip count; at the 7th byte, pause pulses and the FSM goes IDLE; no strb is issued during the skip.
REQ-020 strb, make, code and ext SHALL be registered and SHALL assert exactly one cycle after the rx_strb of the final byte; make, code and ext SHALL hold until the next event.
REQ-021 Repeat filter (FILTER_REPEAT=1):
  - A make whose {ext,code} equals last_make SHALL produce no strb.
  - A break matching last_make SHALL clear last_make to invalid.
  - A break never suppresses.
REQ-022 rx_error SHALL discard the byte, return the FSM to IDLE and clear last_make; when rx_error coincides with rx_strb, the error wins.
REQ-023 The watchdog SHALL count cycles spent in a non-IDLE state with no rx_strb; reaching TIMEOUT_CYCLES SHALL force IDLE with no output.
REQ-024 When rx_strb arrives in the same cycle as watchdog expiry, the byte SHALL be processed in the current state and the counter SHALL be cleared.
REQ-025 The watchdog counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits, saturating, and cleared on every rx_strb and in IDLE.
REQ-026 Back-to-back rx_strb on consecutive cycles SHALL each be processed; no byte is dropped.

Reset
REQ-027 resetn low SHALL asynchronously set:
  - FSM to IDLE, skip count 0, watchdog 0, last_make invalid.
  - strb=0, make=1, code=00, ext=0, pause=0, bat=0.
REQ-028 Reset deassertion mid-sequence SHALL resume in IDLE, so a partial prefix received before reset is lost.

Structure
REQ-029 Shared package ps2_pkg SHALL hold the FSM state enum and the byte constants E0, E1, F0, AA, FA, EE, FE and the fake-shift codes 12 and 59.
REQ-030 The watchdog SHALL be one sub-module, ps2_watchdog (inputs: clear, run; output: expired); all other logic stays in ps2_scan_sequencer.

Verification
REQ-031 Bytes 1C, F0, 1C -> strb with make=0 code=1C ext=0, then strb with make=1 code=1C ext=0, each one cycle after the byte.
REQ-032 Bytes E0 75, E0 F0 75 -> make=0 code=75 ext=1, then make=1 code=75 ext=1; bytes E0 12 -> no strb.
REQ-033 Bytes 1C, 1C, 1C, F0 1C, 1C -> exactly three strb: make, break, make.
REQ-034 Bytes E1 14 77 E1 F0 14 F0 77 -> pause pulses once after the last byte; no strb at any point.
REQ-035 E0, then TIMEOUT_CYCLES idle cycles, then 75 -> make code=75 ext=0; a separate run of F0 with rx_error on the next byte, then 1C -> make code=1C.
REQ-036 Assert resetn low while in E0F0, release, then byte 75 -> make=0 ext=0; all outputs at reset values during reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scancode sequencer.
//   - ps2_state_t : prefix-decoding FSM states
//   - BYTE_*      : PS/2 set-2 prefix, control and response bytes
//   - helpers     : classification of fake-shift and discarded bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_E0     = 3'd1,
    ST_F0     = 3'd2,
    ST_E0F0   = 3'd3,
    ST_E1SKIP = 3'd4
  } ps2_state_t;

  localparam logic [7:0] BYTE_E0   = 8'hE0;  // extended-key prefix
  localparam logic [7:0] BYTE_E1   = 8'hE1;  // Pause sequence prefix
  localparam logic [7:0] BYTE_F0   = 8'hF0;  // break prefix
  localparam logic [7:0] BYTE_AA   = 8'hAA;  // self-test passed
  localparam logic [7:0] BYTE_FA   = 8'hFA;  // ack
  localparam logic [7:0] BYTE_EE   = 8'hEE;  // echo
  localparam logic [7:0] BYTE_FE   = 8'hFE;  // resend request
  localparam logic [7:0] BYTE_00   = 8'h00;  // buffer overrun
  localparam logic [7:0] BYTE_FF   = 8'hFF;  // key detection error
  localparam logic [7:0] FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] FAKE_RSHIFT = 8'h59;

  // Bytes that follow E1 before the Pause sequence is complete.
  localparam logic [2:0] E1_SKIP_BYTES = 3'd7;

  // E0 12 / E0 59 are synthetic shift codes emitted around extended keys.
  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_LSHIFT) || (b == FAKE_RSHIFT);
  endfunction

  // Keyboard responses and error codes that never become key events.
  function automatic logic is_discard(input logic [7:0] b);
    return (b == BYTE_FA) || (b == BYTE_EE) || (b == BYTE_FE) ||
           (b == BYTE_00) || (b == BYTE_FF);
  endfunction

endpackage

// File: rtl/ps2_watchdog.sv
// ps2_watchdog: abandons a stalled prefix sequence.
//   clock, resetn : system clock, async active-low reset
//   clear         : zero the counter (new byte, or FSM idle)
//   run           : FSM is mid-sequence, count this cycle
//   expired       : this is the TIMEOUT_CYCLES-th quiet cycle in a sequence
module ps2_watchdog #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_IDLE = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != CNT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds the number of quiet cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the final allowed one.
  assign expired = run && (r_count >= LAST_IDLE);

endmodule

// File: rtl/ps2_scan_sequencer.sv
// ps2_scan_sequencer: turns a stream of PS/2 set-2 bytes into key events
// for a keyboard matrix.
//   clock, resetn      : system clock, async active-low reset
//   rx_strb/rx_data    : one-cycle strobe with a received byte
//   rx_error           : one-cycle parity/framing error on the current frame
//   strb/make/code/ext : registered key event (make: 0 pressed, 1 released)
//   pause              : Pause key sequence complete
//   bat                : keyboard self-test byte seen
// Valid/ready: there is no back-pressure; every rx_strb cycle carries one
// byte that is consumed in that cycle, and every output is a single pulse
// (make/code/ext hold their value until the next event).
module ps2_scan_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rx_strb,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  output logic       strb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       pause,
  output logic       bat
);

  localparam bit FILTER_ON = (FILTER_REPEAT != 0);

  ps2_state_t  r_state;
  logic [2:0]  r_skip;
  logic        r_last_valid;
  logic [8:0]  r_last_key;    // {ext, code} of the last make still held down
  logic        r_strb, r_make, r_ext, r_pause, r_bat;
  logic [7:0]  r_code;

  ps2_state_t  w_next_state;
  logic [2:0]  w_next_skip;
  logic        w_evt, w_evt_break, w_evt_ext, w_pause, w_bat;
  logic [8:0]  w_key;
  logic        w_repeat, w_emit, w_expired;

  ps2_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .resetn  (resetn),
    .clear   ((r_state == ST_IDLE) || rx_strb),
    .run     (r_state != ST_IDLE),
    .expired (w_expired)
  );

  // Byte decode for the current state; rx_strb takes precedence over a
  // watchdog expiry in the same cycle.
  always_comb begin
    w_next_state = r_state;
    w_next_skip  = r_skip;
    w_evt        = 1'b0;
    w_evt_break  = 1'b0;
    w_evt_ext    = 1'b0;
    w_pause      = 1'b0;
    w_bat        = 1'b0;
    if (rx_strb) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == BYTE_E0) begin
            w_next_state = ST_E0;
          end else if (rx_data == BYTE_F0) begin
            w_next_state = ST_F0;
          end else if (rx_data == BYTE_E1) begin
            w_next_state = ST_E1SKIP;
            w_next_skip  = E1_SKIP_BYTES;
          end else if (rx_data == BYTE_AA) begin
            w_bat = 1'b1;
          end else if (!is_discard(rx_data)) begin
            w_evt = 1'b1;
          end
        end
        ST_E0: begin
          w_next_state = ST_IDLE;
          if (rx_data == BYTE_F0) begin
            w_next_state = ST_E0F0;
          end else if (!is_fake_shift(rx_data)) begin
            w_evt     = 1'b1;
            w_evt_ext = 1'b1;
          end
        end
        ST_F0: begin
          w_next_state = ST_IDLE;
          w_evt        = 1'b1;
          w_evt_break  = 1'b1;
        end
        ST_E0F0: begin
          w_next_state = ST_IDLE;
          if (!is_fake_shift(rx_data)) begin
            w_evt       = 1'b1;
            w_evt_break = 1'b1;
            w_evt_ext   = 1'b1;
          end
        end
        ST_E1SKIP: begin
          w_next_skip = r_skip - 1'b1;
          if (r_skip == 3'd1) begin
            w_pause      = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        default: begin
          w_next_state = ST_IDLE;
          w_next_skip  = '0;
        end
      endcase
    end else if (w_expired) begin
      w_next_state = ST_IDLE;
      w_next_skip  = '0;
    end
  end

  // Typematic filter: a make identical to the key still held is a repeat.
  assign w_key    = {w_evt_ext, rx_data};
  assign w_repeat = r_last_valid && (r_last_key == w_key);
  assign w_emit   = w_evt && (w_evt_break || !(FILTER_ON && w_repeat));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_skip       <= '0;
      r_last_valid <= 1'b0;
      r_last_key   <= '0;
      r_strb       <= 1'b0;
      r_make       <= 1'b1;
      r_code       <= '0;
      r_ext        <= 1'b0;
      r_pause      <= 1'b0;
      r_bat        <= 1'b0;
    end else begin
      r_strb  <= 1'b0;
      r_pause <= 1'b0;
      r_bat   <= 1'b0;
      if (rx_error) begin
        // Corrupt frame: drop the byte and any sequence it belonged to.
        r_state      <= ST_IDLE;
        r_skip       <= '0;
        r_last_valid <= 1'b0;
      end else begin
        r_state <= w_next_state;
        r_skip  <= w_next_skip;
        r_pause <= w_pause;
        r_bat   <= w_bat;
        if (w_emit) begin
          r_strb <= 1'b1;
          r_make <= w_evt_break;
          r_code <= rx_data;
          r_ext  <= w_evt_ext;
        end
        if (w_evt && !w_evt_break) begin
          r_last_key   <= w_key;
          r_last_valid <= 1'b1;
        end else if (w_evt && w_evt_break && w_repeat) begin
          r_last_valid <= 1'b0;
        end
      end
    end
  end

  assign strb  = r_strb;
  assign make  = r_make;
  assign code  = r_code;
  assign ext   = r_ext;
  assign pause = r_pause;
  assign bat   = r_bat;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
// Directed bench for ps2_scan_sequencer with an expected-event queue.
module tb_ps2_scan_sequencer;

  localparam int TO = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       rx_strb = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       strb, make, ext, pause, bat;
  logic [7:0] code;

  ps2_scan_sequencer #(.TIMEOUT_CYCLES(TO), .FILTER_REPEAT(1)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .rx_strb  (rx_strb),
    .rx_data  (rx_data),
    .rx_error (rx_error),
    .strb     (strb),
    .make     (make),
    .code     (code),
    .ext      (ext),
    .pause    (pause),
    .bat      (bat)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL sim_timeout");
    $fatal(1, "simulation time limit reached");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  int pause_cnt = 0;
  int bat_cnt = 0;
  logic [9:0] exp_q[$];      // {make, ext, code}
  int         exp_cyc_q[$];  // cycle count at which strb must be seen

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
    end
  endtask

  always @(negedge clock) begin
    if (pause === 1'b1) pause_cnt++;
    if (bat === 1'b1) bat_cnt++;
    if (strb === 1'b1) begin
      check("strb_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("event", {22'b0, make, ext, code}, {22'b0, exp_q.pop_front()});
        check("event_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All stimulus is applied on the falling edge.
  task automatic expect_evt(input logic m, input logic e, input logic [7:0] c);
    exp_q.push_back({m, e, c});
    exp_cyc_q.push_back(cyc + 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_strb = 1'b1;
    rx_data = b;
    @(negedge clock);
    rx_strb = 1'b0;
  endtask

  task automatic send_err_byte(input logic [7:0] b);
    rx_strb  = 1'b1;
    rx_error = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_strb  = 1'b0;
    rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strb"},  32'(strb),  32'd0);
    check({tag, "_make"},  32'(make),  32'd1);
    check({tag, "_code"},  32'(code),  32'd0);
    check({tag, "_ext"},   32'(ext),   32'd0);
    check({tag, "_pause"}, 32'(pause), 32'd0);
    check({tag, "_bat"},   32'(bat),   32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 resetn = 1'b0;
    idle(3);
    check_reset_outputs("rst");
    resetn = 1'b1;
    idle(2);

    // Plain make / break.
    expect_evt(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);
    send_byte(8'hF0);
    expect_evt(1'b1, 1'b0, 8'h1C); send_byte(8'h1C);
    idle(2);

    // Extended make / break, then fake shifts.
    send_byte(8'hE0);
    expect_evt(1'b0, 1'b1, 8'h75); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0);
    expect_evt(1'b1, 1'b1, 8'h75); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h12);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h59);
    idle(2);

    // Typematic repeats suppressed until the break.
    expect_evt(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    expect_evt(1'b1, 1'b0, 8'h1C); send_byte(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);
    idle(2);

    // Pause sequence: one pause pulse, no key events.
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    idle(3);
    check("pause_count", 32'(pause_cnt), 32'd1);

    // Self-test byte and discarded responses.
    send_byte(8'hAA);
    send_byte(8'hFA); send_byte(8'hEE); send_byte(8'hFE);
    send_byte(8'h00); send_byte(8'hFF);
    idle(3);
    check("bat_count", 32'(bat_cnt), 32'd1);
    check("hold_after_pause", {22'b0, make, ext, code}, {22'b0, 1'b0, 1'b0, 8'h1C});

    // Back-to-back distinct makes.
    expect_evt(1'b0, 1'b0, 8'h2B); send_byte(8'h2B);
    expect_evt(1'b0, 1'b0, 8'h34); send_byte(8'h34);
    idle(2);

    // Watchdog expiry abandons the E0 prefix.
    send_byte(8'hE0);
    idle(TO);
    expect_evt(1'b0, 1'b0, 8'h75); send_byte(8'h75);
    idle(2);

    // Byte on the expiry cycle is still decoded as extended.
    send_byte(8'hE0);
    idle(TO - 1);
    expect_evt(1'b0, 1'b1, 8'h75); send_byte(8'h75);
    idle(2);

    // rx_error drops the prefix and forgets the held key.
    expect_evt(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);
    send_byte(8'hF0);
    send_err_byte(8'h1C);
    expect_evt(1'b0, 1'b0, 8'h1C); send_byte(8'h1C);
    idle(2);

    // Reset in the middle of E0 F0.
    send_byte(8'hE0); send_byte(8'hF0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    idle(2);
    check_reset_outputs("mid_rst_hold");
    resetn = 1'b1;
    idle(1);
    expect_evt(1'b0, 1'b0, 8'h75); send_byte(8'h75);
    idle(5);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("pause_total", 32'(pause_cnt), 32'd1);
    check("bat_total", 32'(bat_cnt), 32'd1);
    check("final_hold", {22'b0, make, ext, code}, {22'b0, 1'b0, 1'b0, 8'h75});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
